mmul_sched: RTL
===============

# mmul_sched

Sequencer for the systolic matrix-multiply datapath. On a `start` pulse it runs the fixed schedule that loads the A/B operand buffers and enables the skewed operand FIFOs (memA/memB) and systolic array. It then drains the DIM result rows through a valid/ready handshake and pulses `done`. It sits between the host/AXI-side register logic and the memA/memB/systolic-array datapath and owns every enable in that datapath.

## Interface

- `DIM`, default 8: array dimension (rows = columns); 2 or greater.
- `CW`, default `$clog2(3*DIM)`: internal cycle-counter width.
- `IW`, default `$clog2(DIM)`: row-index width.

Ports:

- `clk`, in, 1: clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin one multiply; sampled only in IDLE.
- `abort`, in, 1: synchronous; returns to IDLE from any state.
- `out_ready`, in, 1: consumer accepts the current result row.
- `busy`, out, 1: high in LOAD, COMPUTE, DRAIN.
- `done`, out, 1: one-cycle pulse after the last result row is accepted.
- `ld_en`, out, 1: operand-buffer write strobe.
- `ld_idx`, out, IW: row being written while `ld_en` is high.
- `mem_en`, out, 1: shift enable to memA/memB (the `en` of the skewed FIFO banks).
- `sa_en`, out, 1: systolic-array MAC enable.
- `clr_acc`, out, 1: one-cycle accumulator clear.
- `out_valid`, out, 1: result row `c_idx` presented.
- `c_idx`, out, IW: result row select.

## Operation

- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- Reset: state IDLE, counter 0. All outputs are 0: `busy`, `done`, `ld_en`, `ld_idx`, `mem_en`, `sa_en`, `clr_acc`, `out_valid`, `c_idx`.
- **IDLE**
  - `start` = 1 goes to LOAD, counter cleared.
  - `start` is ignored in every other state.
- **LOAD** (DIM cycles)
  - `ld_en` = 1 and `ld_idx` = counter, covering 0..DIM-1.
  - After `ld_idx` = DIM-1, go to COMPUTE with counter cleared.
- **COMPUTE** (3*DIM-1 cycles, counter 0..3*DIM-2)
  - `sa_en` = 1 throughout.
  - `mem_en` = 1 while counter < DIM.
  - `clr_acc` = 1 only at counter 0.
  - The 3*DIM-1 length covers DIM feed cycles, the DIM-cycle enable skew of the operand banks, and DIM-1 cycles of array propagation.
  - After counter = 3*DIM-2, go to DRAIN with `c_idx` = 0.
- **DRAIN**
  - `out_valid` = 1.
  - A row is accepted on a cycle with `out_valid` && `out_ready`; on acceptance `c_idx` increments.
  - With `out_ready` = 0, `c_idx` and `out_valid` hold.
  - Acceptance at `c_idx` = DIM-1 goes to DONE.
- **DONE** (1 cycle)
  - `done` = 1, `busy` = 0, all enables 0.
  - Next state is IDLE unconditionally.
- **abort**
  - Active in any non-IDLE state: next cycle is IDLE and all outputs are 0.
  - No `done` pulse is produced.
  - `abort` beats `start` when both are high in IDLE, so the block stays IDLE.
- `rst` mid-operation: outputs go to 0 immediately (asynchronous). The block is in IDLE at the first edge after `rst` falls.
- All outputs are registered; no combinational path from input to output.
- Counter and index never wrap within a state; each state exit fires exactly at its terminal value.

## Timing

- `start` sampled high at edge 0.
- LOAD spans cycles 1..DIM.
- COMPUTE spans cycles DIM+1..4*DIM-1.
- Earliest `out_valid` is at cycle 4*DIM.
- With `out_ready` held high:
  - DRAIN spans cycles 4*DIM..5*DIM-1.
  - `done` is at cycle 5*DIM.
  - IDLE at cycle 5*DIM+1, where a new `start` is accepted.
- Minimum start-to-start period is 5*DIM+1 cycles.
- Each cycle of `out_ready` low in DRAIN adds exactly one cycle to `done` latency.
- `busy` is high exactly from cycle 1 through the last DRAIN cycle.

## Test plan

- **Nominal run, DIM=4, `out_ready`=1, `start` at cycle 0:**
  - `ld_en` in cycles 1–4 with `ld_idx` 0,1,2,3.
  - `sa_en` in cycles 5–15; `mem_en` in cycles 5–8; `clr_acc` only in cycle 5.
  - `out_valid` in cycles 16–19 with `c_idx` 0..3.
  - `done` in cycle 20; IDLE in cycle 21.
- **Backpressure, DIM=4:** `out_ready` low in cycles 16–17 and 19.
  - `c_idx` holds 0 through cycle 18 and holds 1 in cycle 19.
  - `done` moves to cycle 23.
- **`start` pulses while busy (cycles 3, 10, 17):** the schedule is unchanged from the nominal run, with exactly one `done`.
- **`abort` at cycle 7 (COMPUTE):** cycle 8 shows IDLE with all outputs 0 and no `done`. A `start` at cycle 9 gives `ld_en` at cycle 10.
- **`rst` asserted mid-DRAIN (cycle 17):** all outputs go to 0 before the next edge. After `rst` release the state is IDLE, and a fresh `start` reproduces the nominal schedule.
- **DIM=2 smoke test:** LOAD cycles 1–2, COMPUTE cycles 3–7, DRAIN cycles 8–9, `done` at cycle 10.

Source files
------------

// File: rtl/mmul_sched.sv
// mmul_sched: systolic matmul sequencer (start/abort/out_ready in; busy/done, load/feed/MAC/clear enables, result-row valid/index out)
module mmul_sched #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM),
  parameter int IW  = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          ld_en,
  output logic [IW-1:0] ld_idx,
  output logic          mem_en,
  output logic          sa_en,
  output logic          clr_acc,
  output logic          out_valid,
  output logic [IW-1:0] c_idx
);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        state_d = start ? LOAD : IDLE;
      end
      LOAD: if (cnt == CW'(DIM-1)) begin
        state_d = COMPUTE;
        cnt_d = '0;
      end
      COMPUTE: if (cnt == CW'(3*DIM-2)) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: begin
        cnt_d = cnt + CW'(out_ready);
        if (out_ready && cnt == CW'(DIM-1)) begin
          state_d = DONE;
          cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ld_en <= 1'b0;
      ld_idx <= '0;
      mem_en <= 1'b0;
      sa_en <= 1'b0;
      clr_acc <= 1'b0;
      out_valid <= 1'b0;
      c_idx <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      busy <= state_d inside {LOAD, COMPUTE, DRAIN};
      done <= state_d == DONE;
      ld_en <= state_d == LOAD;
      ld_idx <= state_d == LOAD ? cnt_d[IW-1:0] : '0;
      mem_en <= state_d == COMPUTE && cnt_d < CW'(DIM);
      sa_en <= state_d == COMPUTE;
      clr_acc <= state_d == COMPUTE && cnt_d == '0;
      out_valid <= state_d == DRAIN;
      c_idx <= state_d == DRAIN ? cnt_d[IW-1:0] : '0;
    end
endmodule
